// File: rtl/text_display_pkg.sv
// Shared types and defaults for the text display path: FSM state encoding,
// glyph/grid geometry, the newline code and the pixel colours.
package text_display_pkg;

  localparam int unsigned CHAR_W_DEF = 8;
  localparam int unsigned CHAR_H_DEF = 8;
  localparam int unsigned COLS_DEF   = 20;
  localparam int unsigned ROWS_DEF   = 15;

  localparam logic [6:0] NEWLINE_CODE = 7'h0A;
  localparam logic [2:0] FG_COLOUR    = 3'b111;
  localparam logic [2:0] BG_COLOUR    = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POP     = 3'd1,
    S_LOAD    = 3'd2,
    S_CHECK   = 3'd3,
    S_FETCH   = 3'd4,
    S_DRAW    = 3'd5,
    S_ADVANCE = 3'd6,
    S_NEWLN   = 3'd7
  } state_e;

endpackage

// File: rtl/text_display_cursor.sv
// Text cursor on the character grid: column advance with row wrap, newline,
// and wrap of the row back to the top after the last row.
module text_display_cursor
  import text_display_pkg::*;
#(
  parameter int unsigned COLS  = COLS_DEF,
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned COL_W = $clog2(COLS),
  parameter int unsigned ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             newline,
  output logic [COL_W-1:0] cur_col,
  output logic [ROW_W-1:0] cur_row
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] row_inc;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    row_inc = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
    if (newline) begin
      col_d = '0;
      row_d = row_inc;
    end else if (adv) begin
      if (col_q == COL_W'(COLS - 1)) begin
        col_d = '0;
        row_d = row_inc;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign cur_col = col_q;
  assign cur_row = row_q;

endmodule

// File: rtl/text_display_controller.sv
// Text display sequencer: pops character codes, walks the 8x8 glyph in the
// font ROM and emits one plot per pixel at the current text cursor.
module text_display_controller
  import text_display_pkg::*;
#(
  parameter int unsigned CHAR_W  = CHAR_W_DEF,
  parameter int unsigned CHAR_H  = CHAR_H_DEF,
  parameter int unsigned COLS    = COLS_DEF,
  parameter int unsigned ROWS    = ROWS_DEF,
  parameter logic [6:0]  NEWLINE = NEWLINE_CODE,
  parameter logic [2:0]  FG      = FG_COLOUR,
  parameter logic [2:0]  BG      = BG_COLOUR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic       load_buff_reg,
  input  logic [6:0] buff_reg_out,
  output logic [9:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  localparam int unsigned PX_W  = $clog2(CHAR_W);
  localparam int unsigned PY_W  = $clog2(CHAR_H);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);

  state_e            state_q, state_d;
  logic [PX_W-1:0]   px_q, px_d;
  logic [PY_W-1:0]   py_q, py_d;
  logic [7:0]        row_q, row_d;
  logic              fifo_rd_q, fifo_rd_d;
  logic              load_q, load_d;
  logic              plot_q, plot_d;
  logic              busy_q, busy_d;
  logic [9:0]        rom_addr_q, rom_addr_d;
  logic [7:0]        x_q, x_d;
  logic [6:0]        y_q, y_d;
  logic              cur_adv, cur_nl;
  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic [7:0]        pix_row;
  logic              pix_bit;

  text_display_cursor #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_cursor (
    .clk     (clk),
    .rst     (rst),
    .adv     (cur_adv),
    .newline (cur_nl),
    .cur_col (cur_col),
    .cur_row (cur_row)
  );

  // Next state, counters, and registered outputs decoded from the next state.
  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    row_d      = row_q;
    cur_adv    = 1'b0;
    cur_nl     = 1'b0;
    rom_addr_d = rom_addr_q;
    x_d        = x_q;
    y_d        = y_q;

    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_POP;
      S_POP:   state_d = S_LOAD;
      S_LOAD:  state_d = S_CHECK;
      S_CHECK: begin
        if (buff_reg_out == NEWLINE) begin
          state_d = S_NEWLN;
        end else begin
          py_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        px_d    = '0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if (px_q == '0) row_d = rom_data;
        px_d = px_q + PX_W'(1);
        if (px_q == PX_W'(CHAR_W - 1)) begin
          if (py_q == PY_W'(CHAR_H - 1)) begin
            state_d = S_ADVANCE;
          end else begin
            py_d    = py_q + PY_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_ADVANCE: begin
        cur_adv = 1'b1;
        state_d = S_IDLE;
      end
      S_NEWLN: begin
        cur_nl  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    fifo_rd_d = (state_d == S_POP);
    load_d    = (state_d == S_LOAD);
    plot_d    = (state_d == S_DRAW);
    busy_d    = (state_d != S_IDLE);
    if (state_d == S_FETCH) rom_addr_d = 10'({buff_reg_out, py_d});
    if (state_d == S_DRAW) begin
      x_d = (8'(cur_col) << PX_W) | 8'(px_d);
      y_d = (7'(cur_row) << PY_W) | 7'(py_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      px_q       <= '0;
      py_q       <= '0;
      row_q      <= '0;
      fifo_rd_q  <= 1'b0;
      load_q     <= 1'b0;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      rom_addr_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      row_q      <= row_d;
      fifo_rd_q  <= fifo_rd_d;
      load_q     <= load_d;
      plot_q     <= plot_d;
      busy_q     <= busy_d;
      rom_addr_q <= rom_addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  // ROM data only arrives in the first DRAW cycle of a row, so colour reads it
  // directly for pixel 0 and the captured copy for the remaining pixels.
  assign pix_row = (px_q == '0) ? rom_data : row_q;
  assign pix_bit = pix_row[PX_W'(CHAR_W - 1) - px_q];

  assign fifo_rd       = fifo_rd_q;
  assign load_buff_reg = load_q;
  assign plot          = plot_q;
  assign busy          = busy_q;
  assign rom_addr      = rom_addr_q;
  assign x             = x_q;
  assign y             = y_q;
  assign colour        = plot_q ? (pix_bit ? FG : BG) : 3'b000;

endmodule

// File: doc/text_display_controller.md
# text_display_controller

Sequencing FSM for the text display path. It pops 7-bit character codes from the character FIFO and loads them into the font-address buffer register. It then walks the 8×8 glyph in the font ROM row by row and emits one VGA-adapter plot per pixel at the current text cursor. It also maintains the text cursor on a 20×15 character grid (160×120 pixels), handling wrap-around and the newline code.

## Interface
Parameters:
- CHAR_W, 8, glyph width in pixels (power of two)
- CHAR_H, 8, glyph height in pixels (power of two)
- COLS, 20, text columns
- ROWS, 15, text rows
- NEWLINE, 7'h0A, code that moves the cursor without drawing
- FG, 3'b111, colour for set glyph bits
- BG, 3'b000, colour for clear glyph bits

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- fifo_empty  in  1  character FIFO empty
- fifo_rd  out  1  one-cycle pop strobe; FIFO data is valid on the next cycle
- load_buff_reg  out  1  load strobe to the buffer register
- buff_reg_out  in  7  current character code held by the buffer register
- rom_addr  out  10  font ROM address {buff_reg_out, glyph row[2:0]}
- rom_data  in  8  glyph row from ROM, valid 1 cycle after rom_addr; bit 7 is the leftmost pixel
- x  out  8  pixel x
- y  out  7  pixel y
- colour  out  3  pixel colour
- plot  out  1  pixel write strobe
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, POP, LOAD, CHECK, FETCH, DRAW, ADVANCE, NEWLN.
- IDLE:
  - if !fifo_empty, go to POP; otherwise stay.
  - fifo_empty is sampled only in IDLE.
- POP: fifo_rd=1, then go to LOAD.
- LOAD: load_buff_reg=1, then go to CHECK.
- CHECK:
  - if buff_reg_out==NEWLINE, go to NEWLN;
  - otherwise clear py and go to FETCH.
- FETCH:
  - rom_addr={buff_reg_out,py}; clear px; go to DRAW.
  - rom_data is captured on the first DRAW cycle.
- DRAW:
  - plot=1, x=cur_col*CHAR_W+px, y=cur_row*CHAR_H+py.
  - colour=FG when row bit (7-px) is set, else BG.
  - px increments each cycle.
  - At px==CHAR_W-1: if py==CHAR_H-1, go to ADVANCE; else py++ and go to FETCH.
- ADVANCE:
  - cur_col++.
  - If cur_col==COLS-1, set cur_col=0 and cur_row++.
  - If cur_row==ROWS-1 also wraps, set cur_row=0.
  - Go to IDLE.
- NEWLN:
  - cur_col=0; cur_row++ (wraps to 0 after ROWS-1); no plot; go to IDLE.
- Background pixels are always drawn, so a glyph fully overwrites its cell.
- x and y are computed with shifts of the cursor by log2(CHAR_W) and log2(CHAR_H); the maximum values are 159 and 119.

## Timing
- Reset (asynchronous, rst=0):
  - state=IDLE, cur_col=0, cur_row=0, px=0, py=0.
  - Outputs: fifo_rd, load_buff_reg, plot, busy = 0; rom_addr, x, y, colour = 0.
- Reset mid-glyph abandons the glyph; the partially drawn pixels remain on screen.
- Latency from fifo_empty falling (in IDLE) to the first plot is 5 cycles: IDLE→POP→LOAD→CHECK→FETCH→DRAW.
- A printable character occupies 76 cycles:
  - 3 cycles for POP, LOAD, CHECK;
  - 8 rows × (1 FETCH + 8 DRAW) = 72 cycles;
  - 1 ADVANCE cycle.
  - Plot is high for exactly 64 of these cycles.
- A NEWLINE occupies 4 cycles (POP, LOAD, CHECK, NEWLN) with zero plots.
- Back-to-back characters:
  - there is 1 IDLE cycle after ADVANCE/NEWLN before the next POP;
  - the maximum throughput is 1 printable character per 77 cycles.
- At most one fifo_rd is issued per character. fifo_rd is never asserted when fifo_empty was high in the IDLE cycle.

## Structure
- Shared package text_display_pkg:
  - state enum;
  - NEWLINE;
  - CHAR_W/CHAR_H/COLS/ROWS defaults;
  - FG/BG colour constants.
- Sub-module text_display_cursor:
  - holds cur_col/cur_row;
  - inputs `adv` and `newline`;
  - implements both wrap rules;
  - is instantiated once.
- The FSM, the px/py counters and the pixel address/colour generation live in the top module.

## Test plan
- Reset with the FIFO empty: all outputs are 0 and busy=0; hold 20 cycles: fifo_rd never asserts.
- Push 'A' (7'h41) with the ROM row 8'b1000_0001 for all rows:
  - 64 plots at x=0..7, y=0..7;
  - colour=7 only at x=0 and x=7;
  - the first plot is 5 cycles after fifo_empty falls;
  - busy is high for 76 cycles.
- Push 20 printable characters and then 'B': 'B' is drawn at x=0..7, y=8..15 (column wrap).
- Set the cursor to row 14, column 5, then push 7'h0A:
  - no plot, 4 busy cycles;
  - cursor becomes (0,0);
  - the next glyph is drawn at y=0..7.
- Push 20×15 printable characters and then one more: the extra glyph is drawn at (0,0) (full-screen wrap).
- Assert rst low at the 30th DRAW cycle of a glyph:
  - plot drops immediately (asynchronously) and the state is IDLE;
  - after release, the next character is drawn at (0,0).
